frame_loader_pad: RTL and testbench
===================================

Name: frame_loader_pad

Overview:
Front-end writer for the 3x3 convolution frame buffer. It accepts a raster pixel stream of one 64x64 frame over a valid/ready handshake and writes the pixels into the interior of the (IMG_H+2)x(IMG_W+2) buffer. It also writes the one-pixel zero border around them. When the frame is complete it pulses frame_done so the window reader can start.

Parameters:
IMG_W, 64, active image width in pixels
IMG_H, 64, active image height in pixels
DW, 8, pixel width in bits
AW, 7, row/column address width; must satisfy 2^AW >= max(IMG_W,IMG_H)+2

Ports:
clk  in  1  clock
rst_n  in  1  reset
start  in  1  single-cycle request to load one frame
s_valid  in  1  input pixel valid
s_data  in  DW  input pixel, raster order (row-major, left to right)
s_last  in  1  marks the last pixel of the frame
s_ready  out  1  loader can accept a pixel
m_wr_en  out  1  buffer write strobe
m_wr_row  out  AW  buffer row address, 0..IMG_H+1
m_wr_col  out  AW  buffer column address, 0..IMG_W+1
m_wr_data  out  DW  buffer write data
busy  out  1  high in BORDER and LOAD
frame_done  out  1  one-cycle pulse at end of frame
err_len  out  1  frame length error; sticky

Interface decision: reset rst_n, synchronous, active-low; clock clk.

Behaviour:
- Reset: state=IDLE; all counters 0. Outputs s_ready, m_wr_en, busy, frame_done, err_len = 0; m_wr_row, m_wr_col, m_wr_data = 0.
- Reset mid-operation: same as above; buffer contents undefined afterwards.
- FSM states: IDLE, BORDER, LOAD, DONE.
- IDLE:
  - s_ready=0.
  - start=1 -> BORDER; clear err_len and all counters.
- BORDER: one zero write per cycle, 2*(IMG_W+2)+2*IMG_H = 260 writes, in this order:
  - row 0, cols 0..IMG_W+1;
  - row IMG_H+1, cols 0..IMG_W+1;
  - then for r=1..IMG_H: (r,0) followed by (r,IMG_W+1).
  - After the 260th write -> LOAD.
  - s_ready=0 throughout.
- LOAD:
  - s_ready=1 (combinational from state).
  - Accepted beat is s_valid&&s_ready. Each accepted beat writes s_data at (pr+1, pc+1), where pr/pc are the pixel counters.
  - pc wraps at IMG_W-1 and increments pr.
  - Beats with s_valid=0 produce no write and no counter movement.
- End of frame:
  - Normal: beat 4095 with s_last=1 -> DONE.
  - Early s_last (beat index < 4095): write that pixel, set err_len=1, -> DONE. The remaining interior is left unwritten.
  - Beat 4095 with s_last=0: write it, set err_len=1, -> DONE.
- DONE:
  - frame_done=1 for exactly one cycle, then -> IDLE.
  - s_ready=0.
- Write port timing:
  - m_wr_en/row/col/data are registered, so they appear 1 cycle after the generating state cycle or accepted beat.
  - m_wr_en=0 in every other cycle; row/col/data hold their last values.
- busy is registered from state: high when state is BORDER or LOAD.
- start while busy or in DONE: ignored; no restart.
- err_len holds until the next accepted start.
- Cycle budget with continuous s_valid: start at edge 0 gives the first border write visible at edge 2. Total frame time is 1 + 260 + 4096 + 1 cycles.
- Address arithmetic:
  - Interior address is counter+1, computed at AW bits with no overflow.
  - Border counter is 9 bits, sized to hold 0..259.

Decomposition:
- Shared package conv_pkg holds:
  - IMG_W, IMG_H, DW, AW constants;
  - derived BUF_W = IMG_W+2 and BUF_H = IMG_H+2;
  - state enum loader_state_t {IDLE, BORDER, LOAD, DONE}.
  - The window reader and the result writer reuse the same package.
- One sub-module, frame_border_gen, is the natural split:
  - it is a counter that emits the border (row,col) sequence and a last flag;
  - it is enabled by the FSM while in BORDER.

Test Plan:
- Reset then start, observe BORDER -> exactly 260 m_wr_en pulses with data 0. Addresses: first (0,0), 66th (0,65), 67th (65,0), 133rd (1,0), 134th (1,65), last (64,65). No writes land on interior cells.
- Full frame with continuous s_valid and s_data=index mod 256, s_last on beat 4095:
  - 4096 writes; first (1,1)=0x00, 65th (2,1)=0x40, last (64,64)=0xFF;
  - frame_done pulses once, 1 cycle after the last write is issued; err_len=0.
- Random s_valid gaps (~50% duty): write count and addresses identical to the continuous case; no write in any cycle without an accepted beat; s_ready=0 in IDLE and BORDER.
- s_last on beat 99: the 100th write is at (2,36); err_len=1 and frame_done pulses. A second start clears err_len.
- s_last never asserted: after 4096 beats, err_len=1 and frame_done pulses; s_ready=0 afterwards.
- start asserted during LOAD has no effect. rst_n=0 at beat 2000 gives IDLE next cycle with all outputs 0; a new start then reruns the full sequence from the (0,0) border write.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and types for the 3x3 convolution frame-buffer blocks.
// Used by the frame loader, the window reader and the result writer.
//   IMG_W/IMG_H : active image size in pixels
//   DW          : pixel width in bits
//   AW          : row/column address width of the padded buffer
//   BUF_W/BUF_H : padded buffer size (one zero pixel on every side)
package conv_pkg;
  localparam int IMG_W = 64;
  localparam int IMG_H = 64;
  localparam int DW    = 8;
  localparam int AW    = 7;

  localparam int BUF_W = IMG_W + 2;
  localparam int BUF_H = IMG_H + 2;

  // Border cells: two full rows plus the left/right cells of every interior row.
  localparam int BORDER_N = 2 * BUF_W + 2 * IMG_H;
  localparam int BCW      = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BORDER = 2'd1,
    LOAD   = 2'd2,
    DONE   = 2'd3
  } loader_state_t;
endpackage

// File: rtl/frame_border_gen.sv
// Border address generator for the padded frame buffer.
// Walks the zero border in the order: top row, bottom row, then the
// (r,0)/(r,BUF_W-1) pairs for r = 1..IMG_H.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : restart the sequence at (0,0)
//   en         : advance one border cell
//   row, col   : current border cell address
//   last       : current cell is the final one of the sequence
module frame_border_gen
  import conv_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [AW-1:0] row,
  output logic [AW-1:0] col,
  output logic          last
);

  logic [BCW-1:0] cnt_q, cnt_d;
  logic [BCW-1:0] side_idx;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  always_comb begin
    side_idx = '0;
    row      = '0;
    col      = '0;
    if (cnt_q < BCW'(BUF_W)) begin
      row = '0;
      col = AW'(cnt_q);
    end else if (cnt_q < BCW'(2 * BUF_W)) begin
      row = AW'(BUF_H - 1);
      col = AW'(cnt_q - BCW'(BUF_W));
    end else begin
      // Side cells come in pairs: even index is the left cell, odd the right.
      side_idx = cnt_q - BCW'(2 * BUF_W);
      row      = AW'(side_idx[BCW-1:1]) + AW'(1);
      col      = side_idx[0] ? AW'(BUF_W - 1) : '0;
    end
  end

  assign last = (cnt_q == BCW'(BORDER_N - 1));

endmodule

// File: rtl/frame_loader_pad.sv
// Front-end writer for the padded 3x3 convolution frame buffer.
// On start it writes the zero border, then streams one raster frame into
// the buffer interior at (row+1, col+1), then pulses frame_done.
//   clk, rst_n        : clock, synchronous active-low reset
//   start             : single-cycle request to load one frame (IDLE only)
//   s_valid/s_ready   : pixel stream handshake; s_data pixel, s_last end marker
//   m_wr_en/row/col/data : registered buffer write port
//   busy              : registered, high while writing border or pixels
//   frame_done        : one-cycle pulse at end of frame
//   err_len           : sticky frame-length error, cleared by the next start
module frame_loader_pad
  import conv_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic          s_ready,
  output logic          m_wr_en,
  output logic [AW-1:0] m_wr_row,
  output logic [AW-1:0] m_wr_col,
  output logic [DW-1:0] m_wr_data,
  output logic          busy,
  output logic          frame_done,
  output logic          err_len
);

  loader_state_t state_q, state_d;

  logic [AW-1:0] pr_q, pr_d, pc_q, pc_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_row_q, wr_row_d, wr_col_q, wr_col_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  logic          accept, last_pix, start_ok;
  logic [AW-1:0] bg_row, bg_col;
  logic          bg_last;

  assign start_ok = (state_q == IDLE) && start;
  assign accept   = s_valid && s_ready;
  assign last_pix = (pr_q == AW'(IMG_H - 1)) && (pc_q == AW'(IMG_W - 1));

  frame_border_gen u_border (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_ok),
    .en    (state_q == BORDER),
    .row   (bg_row),
    .col   (bg_col),
    .last  (bg_last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = BORDER;
      BORDER:  if (bg_last) state_d = LOAD;
      LOAD:    if (accept && (s_last || last_pix)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    s_ready    = (state_q == LOAD);
    frame_done = (state_q == DONE);
  end

  // Counters, write port and status
  always_comb begin
    pr_d      = pr_q;
    pc_d      = pc_q;
    wr_en_d   = 1'b0;
    wr_row_d  = wr_row_q;
    wr_col_d  = wr_col_q;
    wr_data_d = wr_data_q;
    err_d     = err_q;
    busy_d    = (state_q == BORDER) || (state_q == LOAD);

    if (start_ok) begin
      pr_d  = '0;
      pc_d  = '0;
      err_d = 1'b0;
    end

    if (state_q == BORDER) begin
      wr_en_d   = 1'b1;
      wr_row_d  = bg_row;
      wr_col_d  = bg_col;
      wr_data_d = '0;
    end

    if (accept) begin
      wr_en_d   = 1'b1;
      wr_row_d  = pr_q + AW'(1);
      wr_col_d  = pc_q + AW'(1);
      wr_data_d = s_data;
      if (pc_q == AW'(IMG_W - 1)) begin
        pc_d = '0;
        pr_d = pr_q + AW'(1);
      end else begin
        pc_d = pc_q + AW'(1);
      end
      // Length error: s_last early, or missing on the final pixel.
      if (s_last != last_pix) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pr_q      <= '0;
      pc_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_row_q  <= '0;
      wr_col_q  <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pr_q      <= pr_d;
      pc_q      <= pc_d;
      wr_en_q   <= wr_en_d;
      wr_row_q  <= wr_row_d;
      wr_col_q  <= wr_col_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign m_wr_en   = wr_en_q;
  assign m_wr_row  = wr_row_q;
  assign m_wr_col  = wr_col_q;
  assign m_wr_data = wr_data_q;
  assign busy      = busy_q;
  assign err_len   = err_q;

endmodule

// File: tb/tb_frame_loader_pad.sv
// Directed bench for frame_loader_pad: border sequence, full frames with and
// without stream gaps, length errors, start during load and mid-frame reset.
module tb_frame_loader_pad;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_ready;
  logic       m_wr_en;
  logic [6:0] m_wr_row;
  logic [6:0] m_wr_col;
  logic [7:0] m_wr_data;
  logic       busy;
  logic       frame_done;
  logic       err_len;

  frame_loader_pad dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .m_wr_en    (m_wr_en),
    .m_wr_row   (m_wr_row),
    .m_wr_col   (m_wr_col),
    .m_wr_data  (m_wr_data),
    .busy       (busy),
    .frame_done (frame_done),
    .err_len    (err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Per-frame observation state
  int   wrow [0:4399];
  int   wcol [0:4399];
  int   wdat [0:4399];
  int   wr_n, cyc, beat, fd_n, fd_cyc, first_cyc;
  int   addr_bad, gap_bad, ready_bad;
  logic err_c1, post_ready, post_busy, busy_mid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected address of the k-th write of a frame (border first, then raster interior).
  function automatic void exp_addr(input int k, output int r, output int c, output int d);
    int j;
    d = 0;
    if (k < 66) begin
      r = 0;  c = k;
    end else if (k < 132) begin
      r = 65; c = k - 66;
    end else if (k < 260) begin
      r = 1 + (k - 132) / 2;
      c = ((k - 132) % 2 == 1) ? 65 : 0;
    end else begin
      j = k - 260;
      r = j / 64 + 1;
      c = j % 64 + 1;
      d = j % 256;
    end
  endfunction

  task automatic clock_cycle();
    logic acc;
    int   r, c, d;
    acc = s_valid && s_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (cyc == 1) err_c1 = err_len;
    if (wr_n >= 260 && m_wr_en !== acc) gap_bad++;
    if (m_wr_en === 1'b1) begin
      exp_addr(wr_n, r, c, d);
      if (m_wr_row != 7'(r) || m_wr_col != 7'(c) || m_wr_data != 8'(d)) addr_bad++;
      if (wr_n < 4400) begin
        wrow[wr_n] = int'(m_wr_row);
        wcol[wr_n] = int'(m_wr_col);
        wdat[wr_n] = int'(m_wr_data);
      end
      if (wr_n == 0) first_cyc = cyc;
      wr_n++;
    end
    if (acc) beat++;
    if (beat == 1000) busy_mid = busy;
    if (frame_done === 1'b1) begin
      fd_n++;
      fd_cyc = cyc;
    end
    if (s_ready === 1'b1 && wr_n < 260) ready_bad++;
  endtask

  task automatic run_frame(input int last_at, input bit gaps, input int start_at, input int reset_at);
    bit start_sent;
    bit aborted;
    wr_n = 0; cyc = 0; beat = 0; fd_n = 0; fd_cyc = -1; first_cyc = -1;
    addr_bad = 0; gap_bad = 0; ready_bad = 0;
    err_c1 = 1'bx; busy_mid = 1'bx;
    start_sent = 0; aborted = 0;
    start = 1'b1; s_valid = 1'b0; s_last = 1'b0;
    clock_cycle();
    start = 1'b0;
    while (fd_n == 0 && cyc < 10000) begin
      if (reset_at >= 0 && beat == reset_at) begin
        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        clock_cycle();
        rst_n = 1'b1;
        aborted = 1;
        break;
      end
      start   = (start_at >= 0 && beat == start_at && !start_sent);
      if (start) start_sent = 1;
      s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = 8'(beat);
      s_last  = (beat == last_at);
      clock_cycle();
    end
    start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    if (!aborted) begin
      clock_cycle();
      post_ready = s_ready;
      post_busy  = busy;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_wr_en"},   m_wr_en, 0);
    check({tag, "_busy"},    busy, 0);
    check({tag, "_done"},    frame_done, 0);
    check({tag, "_err"},     err_len, 0);
    check({tag, "_row"},     m_wr_row, 0);
    check({tag, "_col"},     m_wr_col, 0);
    check({tag, "_data"},    m_wr_data, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_idle_outputs("reset");

    // Continuous frame, s_last on beat 4095
    run_frame(4095, 0, -1, -1);
    check("f1_writes",    wr_n, 4356);
    check("f1_first_cyc", first_cyc, 2);
    check("f1_w0_row",    wrow[0], 0);    check("f1_w0_col",    wcol[0], 0);
    check("f1_w65_row",   wrow[65], 0);   check("f1_w65_col",   wcol[65], 65);
    check("f1_w66_row",   wrow[66], 65);  check("f1_w66_col",   wcol[66], 0);
    check("f1_w132_row",  wrow[132], 1);  check("f1_w132_col",  wcol[132], 0);
    check("f1_w133_row",  wrow[133], 1);  check("f1_w133_col",  wcol[133], 65);
    check("f1_w259_row",  wrow[259], 64); check("f1_w259_col",  wcol[259], 65);
    check("f1_w259_data", wdat[259], 0);
    check("f1_px0_row",   wrow[260], 1);  check("f1_px0_col",   wcol[260], 1);
    check("f1_px0_data",  wdat[260], 0);
    check("f1_px64_row",  wrow[324], 2);  check("f1_px64_col",  wcol[324], 1);
    check("f1_px64_data", wdat[324], 8'h40);
    check("f1_last_row",  wrow[4355], 64); check("f1_last_col", wcol[4355], 64);
    check("f1_last_data", wdat[4355], 8'hFF);
    check("f1_addr_bad",  addr_bad, 0);
    check("f1_gap_bad",   gap_bad, 0);
    check("f1_ready_bad", ready_bad, 0);
    check("f1_done_cnt",  fd_n, 1);
    check("f1_done_cyc",  fd_cyc, 4357);
    check("f1_err",       err_len, 0);
    check("f1_busy_mid",  busy_mid, 1);
    check("f1_post_rdy",  post_ready, 0);
    check("f1_post_busy", post_busy, 0);

    // Random gaps on s_valid
    run_frame(4095, 1, -1, -1);
    check("f2_writes",    wr_n, 4356);
    check("f2_addr_bad",  addr_bad, 0);
    check("f2_gap_bad",   gap_bad, 0);
    check("f2_ready_bad", ready_bad, 0);
    check("f2_done_cnt",  fd_n, 1);
    check("f2_err",       err_len, 0);

    // Early s_last on beat 99
    run_frame(99, 0, -1, -1);
    check("f3_writes",    wr_n, 360);
    check("f3_w100_row",  wrow[359], 2);
    check("f3_w100_col",  wcol[359], 36);
    check("f3_w100_data", wdat[359], 99);
    check("f3_err",       err_len, 1);
    check("f3_done_cnt",  fd_n, 1);

    // s_last never asserted; the new start must first clear err_len
    run_frame(-1, 0, -1, -1);
    check("f4_err_clear", err_c1, 0);
    check("f4_writes",    wr_n, 4356);
    check("f4_addr_bad",  addr_bad, 0);
    check("f4_err",       err_len, 1);
    check("f4_done_cnt",  fd_n, 1);
    check("f4_done_cyc",  fd_cyc, 4357);
    check("f4_post_rdy",  post_ready, 0);

    // start during LOAD ignored, then reset at beat 2000
    run_frame(4095, 0, 500, 2000);
    check("f5_writes",    wr_n, 2260);
    check("f5_addr_bad",  addr_bad, 0);
    check("f5_gap_bad",   gap_bad, 0);
    check("f5_done_cnt",  fd_n, 0);
    check_idle_outputs("f5_rst");

    // Full rerun after the mid-frame reset
    run_frame(4095, 0, -1, -1);
    check("f6_writes",    wr_n, 4356);
    check("f6_first_cyc", first_cyc, 2);
    check("f6_w0_row",    wrow[0], 0);
    check("f6_w0_col",    wcol[0], 0);
    check("f6_addr_bad",  addr_bad, 0);
    check("f6_done_cyc",  fd_cyc, 4357);
    check("f6_err",       err_len, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
